alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Shares one combinational 32-bit ALU between two requesters, e.g. the core execute stage (port 0) and a debug/DMA engine (port 1).
- Arbitrates round-robin and registers the granted operation for one cycle while driving the external ALU.
- Captures the ALU result into a per-requester response buffer with valid/ready backpressure.
- Sits between the requesters and the ALU instance; the ALU op encoding is passed through untouched.

Parameters:
- OP_W, 6, ALU op code width (same encoding the ALU decodes)
- DATA_W, 32, operand/result width
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready
- req0_op  in  OP_W  requester 0 ALU op code
- req0_a  in  DATA_W  requester 0 operand 1
- req0_b  in  DATA_W  requester 0 operand 2
- rsp0_valid  out  1  requester 0 result available
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_data  out  DATA_W  requester 0 result
- req1_valid, req1_ready, req1_op, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_data: same as port 0, for requester 1
- alu_op  out  OP_W  op code to ALU
- alu_rv1  out  DATA_W  operand 1 to ALU
- alu_rv2  out  DATA_W  operand 2 to ALU
- alu_rvout  in  DATA_W  ALU combinational result
- busy  out  1  operation in EXEC this cycle
- op_count  out  CNT_W  completed operations, wrapping

Behaviour:
- Reset (async, immediate, any state):
  - state=IDLE; reqN_ready=0; rspN_valid=0, rspN_data=0.
  - alu_op/rv1/rv2=0; busy=0; op_count=0; last_grant=1, so port 0 wins the first tie.
  - Any in-flight or buffered result is discarded.
- FSM states:
  - IDLE: nothing in flight.
  - EXEC: issue register holds op, a, b and id.
- Eligibility of port i:
  - Requires reqi_valid.
  - Port i must not be in flight: not (state==EXEC and id==i).
  - Response buffer i must be free: rspi_valid==0 or rspi_ready==1 in the same cycle.
  - At most one outstanding operation per requester, counting both in-flight and buffered.
- Grant (combinational, any state):
  - One eligible port: that port.
  - Both eligible: the port != last_grant.
  - reqi_ready=1 only for the granted port; never both.
  - reqi_ready may depend on reqi_valid.
- Accept at edge E0:
  - Issue register <= granted op/a/b/id; last_grant <= id; state=EXEC.
- EXEC cycle:
  - alu_op/alu_rv1/alu_rv2 driven from the issue register; busy=1.
  - At the next edge E1: rsp{id}_data <= alu_rvout, rsp{id}_valid <= 1, op_count <= op_count+1 (wraps 2^CNT_W-1 -> 0).
  - If another grant exists in the same cycle: stay EXEC with the new issue contents (throughput 1 op/cycle). Otherwise -> IDLE.
- IDLE: alu_op/alu_rv1/alu_rv2 = 0 (ALU then outputs 0); busy=0.
- Latency: request presented and accepted in cycle k -> rspN_valid=1 in cycle k+2 (one EXEC cycle).
- Response buffer:
  - rspi_valid clears at the edge where rspi_valid&rspi_ready, unless a new result is captured at that edge, in which case it stays 1 with the new data.
  - rspi_data holds stable while rspi_valid=1 and not consumed.
- Op codes are not checked. Unknown codes produce whatever the ALU returns (0 by its default) and still count as completed.
- Requester operands need be stable only in the accept cycle.
- A requester dropping valid without ready is permitted; no state changes.

Test Plan:
- Single op: after reset, port 0 presents op=6'b000011 (ADD), a=5, b=7 in cycle 1 -> req0_ready=1 cycle 1; busy=1 cycle 2 with alu_rv1=5; rsp0_valid=1, rsp0_data=12 in cycle 3; op_count=1.
- Tie + round-robin: both ports valid every cycle, rsp ready held 1. Port 0 SUB (6'b100011) 10,3; port 1 SLT (6'b001011) -1,0.
  - Grants alternate 0,1,0,1 starting with 0.
  - rsp0_data=7, rsp1_data=1.
  - busy continuous; op_count +1 per cycle.
- Backpressure: port 1 result pending with rsp1_ready=0 for 5 cycles while req1_valid=1 -> req1_ready=0 throughout and rsp1_data stable. Port 0 (AND 6'b011111, 0xF0F0,0xFF00 -> 0xF000) still granted every other cycle. Raising rsp1_ready re-enables port 1 in the same cycle.
- Drain + refill same edge: rsp0_valid=1, rsp0_ready=1 and a new port 0 op accepted that cycle -> result two cycles later. rsp0_valid drops for exactly one cycle between results; no result lost.
- Reset mid-operation: assert reset asynchronously during EXEC with rsp1_valid=1 -> all outputs 0 immediately, op_count=0. After release, the first tie grants port 0.
- Counter wrap: preload via 65535 completed ops -> op_count=65535. The next completion -> op_count=0.

Source files
------------

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One registered issue slot drives the ALU; results land in per-port response buffers.
module alu_share_arb #(
  parameter int OP_W   = 6,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_rv1,
  output logic [DATA_W-1:0] alu_rv2,
  input  logic [DATA_W-1:0] alu_rvout,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t              state_q, state_d;
  logic                id_q, id_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                last_q, last_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0]   rsp0_data_q, rsp0_data_d;
  logic [DATA_W-1:0]   rsp1_data_q, rsp1_data_d;
  logic [CNT_W-1:0]    op_count_q, op_count_d;

  logic elig0, elig1, gnt0, gnt1;

  always_comb begin
    // A port may have only one operation outstanding (in flight or buffered).
    elig0 = req0_valid && !(state_q == EXEC && id_q == 1'b0) && (!rsp0_valid_q || rsp0_ready);
    elig1 = req1_valid && !(state_q == EXEC && id_q == 1'b1) && (!rsp1_valid_q || rsp1_ready);
    gnt0  = elig0 && (!elig1 || last_q);
    gnt1  = elig1 && (!elig0 || !last_q);
  end

  always_comb begin
    state_d = IDLE;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    last_d  = last_q;
    if (gnt0 || gnt1) begin
      state_d = EXEC;
      id_d    = gnt1;
      op_d    = gnt1 ? req1_op : req0_op;
      a_d     = gnt1 ? req1_a  : req0_a;
      b_d     = gnt1 ? req1_b  : req0_b;
      last_d  = gnt1;
    end
  end

  always_comb begin
    rsp0_valid_d = rsp0_valid_q && !rsp0_ready;
    rsp1_valid_d = rsp1_valid_q && !rsp1_ready;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    op_count_d   = op_count_q;
    if (state_q == EXEC) begin
      op_count_d = op_count_q + CNT_W'(1);
      if (id_q) begin
        rsp1_valid_d = 1'b1;
        rsp1_data_d  = alu_rvout;
      end else begin
        rsp0_valid_d = 1'b1;
        rsp0_data_d  = alu_rvout;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      id_q         <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      last_q       <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      last_q       <= last_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      op_count_q   <= op_count_d;
    end
  end

  // Readies are masked during reset so nothing appears accepted while state is held.
  assign req0_ready = gnt0 && !reset;
  assign req1_ready = gnt1 && !reset;
  assign busy       = (state_q == EXEC);
  assign alu_op     = busy ? op_q : '0;
  assign alu_rv1    = busy ? a_q  : '0;
  assign alu_rv2    = busy ? b_q  : '0;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios plus randomized traffic against a
// transaction-level reference model; also models the external ALU.
module tb_alu_share_arb;

  localparam logic [5:0] OP_ADD = 6'b000011;
  localparam logic [5:0] OP_SUB = 6'b100011;
  localparam logic [5:0] OP_SLT = 6'b001011;
  localparam logic [5:0] OP_AND = 6'b011111;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [5:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_data, rsp1_data;
  logic [31:0] alu_rv1, alu_rv2, alu_rvout;
  logic        busy;
  logic [15:0] op_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.OP_W(6), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_op(alu_op), .alu_rv1(alu_rv1), .alu_rv2(alu_rv2), .alu_rvout(alu_rvout),
    .busy(busy), .op_count(op_count)
  );

  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return {31'd0, ($signed(a) < $signed(b))};
      OP_AND:  return a & b;
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_rvout = alu_fn(alu_op, alu_rv1, alu_rv2);

  task automatic clear_inputs;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0; rsp0_ready = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0; rsp1_ready = 0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    #3;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clear_inputs();
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    @(negedge clk);
    #1;
    n_vec++;
    if ({req0_ready, req1_ready, busy, rsp0_valid, rsp1_valid} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 00000", {req0_ready, req1_ready, busy, rsp0_valid, rsp1_valid});
    end
    n_vec++;
    if ({alu_op, alu_rv1, alu_rv2, rsp0_data, rsp1_data, op_count} !== '0) begin
      n_err++; $display("FAIL reset_values: op=%0h rv1=%0h rv2=%0h d0=%0h d1=%0h cnt=%0d expected all 0",
                        alu_op, alu_rv1, alu_rv2, rsp0_data, rsp1_data, op_count);
    end
  endtask

  task automatic test_single_op;
    do_reset();
    req0_valid = 1; req0_op = OP_ADD; req0_a = 5; req0_b = 7;
    #1;
    n_vec++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 0; req0_a = 32'hDEAD;
    #1;
    n_vec++;
    if (busy !== 1'b1 || alu_rv1 !== 32'd5 || alu_rv2 !== 32'd7 || alu_op !== OP_ADD) begin
      n_err++; $display("FAIL single_exec: busy=%b rv1=%0d rv2=%0d op=%0h expected 1 5 7 3", busy, alu_rv1, alu_rv2, alu_op);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd12 || op_count !== 16'd1 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_rsp: valid=%b data=%0d cnt=%0d busy=%b expected 1 12 1 0", rsp0_valid, rsp0_data, op_count, busy);
    end
    rsp0_ready = 1;
    @(negedge clk);
    #1;
    n_vec++;
    if (rsp0_valid !== 1'b0) begin
      n_err++; $display("FAIL single_drain: valid=%b expected 0", rsp0_valid);
    end
  endtask

  task automatic test_round_robin;
    do_reset();
    req0_valid = 1; req0_op = OP_SUB; req0_a = 10; req0_b = 3;
    req1_valid = 1; req1_op = OP_SLT; req1_a = 32'hFFFF_FFFF; req1_b = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_vec++;
      if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      n_vec++;
      if (busy !== (i >= 1) || op_count !== 16'((i >= 1) ? i - 1 : 0)) begin
        n_err++; $display("FAIL rr_busy_cnt[%0d]: busy=%b cnt=%0d expected %b %0d", i, busy, op_count, i >= 1, (i >= 1) ? i - 1 : 0);
      end
      if (i >= 2) begin
        n_vec++;
        if (i % 2 == 0 && (rsp0_valid !== 1'b1 || rsp0_data !== 32'd7 || rsp1_valid !== 1'b0)) begin
          n_err++; $display("FAIL rr_rsp0[%0d]: v0=%b d0=%0d v1=%b expected 1 7 0", i, rsp0_valid, rsp0_data, rsp1_valid);
        end
        if (i % 2 == 1 && (rsp1_valid !== 1'b1 || rsp1_data !== 32'd1 || rsp0_valid !== 1'b0)) begin
          n_err++; $display("FAIL rr_rsp1[%0d]: v1=%b d1=%0d v0=%b expected 1 1 0", i, rsp1_valid, rsp1_data, rsp0_valid);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    req0_valid = 1; req0_op = OP_AND; req0_a = 32'hF0F0; req0_b = 32'hFF00;
    req1_valid = 1; req1_op = OP_ADD; req1_a = 1; req1_b = 2;
    rsp0_ready = 1; rsp1_ready = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 8) rsp1_ready = 1;
      #1;
      if (i < 3) begin
        n_vec++;
        if ({req0_ready, req1_ready} !== ((i == 1) ? 2'b01 : 2'b10)) begin
          n_err++; $display("FAIL bp_start[%0d]: got %b expected %b", i, {req0_ready, req1_ready}, (i == 1) ? 2'b01 : 2'b10);
        end
      end else if (i < 8) begin
        n_vec++;
        if (req1_ready !== 1'b0 || req0_ready !== (i % 2 == 0)) begin
          n_err++; $display("FAIL bp_grant[%0d]: r0=%b r1=%b expected %b 0", i, req0_ready, req1_ready, i % 2 == 0);
        end
        n_vec++;
        if (rsp1_valid !== 1'b1 || rsp1_data !== 32'd3) begin
          n_err++; $display("FAIL bp_hold[%0d]: v1=%b d1=%0d expected 1 3", i, rsp1_valid, rsp1_data);
        end
        if (i % 2 == 0) begin
          n_vec++;
          if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h0000_F000) begin
            n_err++; $display("FAIL bp_rsp0[%0d]: v0=%b d0=%0h expected 1 f000", i, rsp0_valid, rsp0_data);
          end
        end
      end else begin
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
          n_err++; $display("FAIL bp_release: got %b expected 01", {req0_ready, req1_ready});
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    req0_valid = 1; req0_op = OP_ADD; req0_b = 10; rsp0_ready = 1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      req0_a = i;
      #1;
      n_vec++;
      if (req0_ready !== (i % 2 == 0)) begin
        n_err++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, req0_ready, i % 2 == 0);
      end
      n_vec++;
      if (rsp0_valid !== (i >= 2 && i % 2 == 0)) begin
        n_err++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, rsp0_valid, i >= 2 && i % 2 == 0);
      end
      if (i >= 2 && i % 2 == 0) begin
        n_vec++;
        if (rsp0_data !== 32'(i + 8)) begin
          n_err++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, rsp0_data, i + 8);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    req0_valid = 1; req0_op = OP_ADD; req0_a = 4; req0_b = 4;
    req1_valid = 1; req1_op = OP_ADD; req1_a = 9; req1_b = 9;
    rsp0_ready = 1; rsp1_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b1 || rsp1_valid !== 1'b1 || rsp1_data !== 32'd18 || op_count !== 16'd2) begin
      n_err++; $display("FAIL mid_pre: busy=%b v1=%b d1=%0d cnt=%0d expected 1 1 18 2", busy, rsp1_valid, rsp1_data, op_count);
    end
    #1 reset = 1'b1;
    #1;
    n_vec++;
    if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 5'b0 ||
        {alu_op, alu_rv1, alu_rv2, rsp0_data, rsp1_data, op_count} !== '0) begin
      n_err++; $display("FAIL mid_reset: busy=%b v0=%b v1=%b op=%0h rv1=%0h d0=%0h d1=%0h cnt=%0d expected all 0",
                        busy, rsp0_valid, rsp1_valid, alu_op, alu_rv1, rsp0_data, rsp1_data, op_count);
    end
    @(negedge clk);
    reset = 1'b0;
    rsp1_ready = 1;
    #1;
    n_vec++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL mid_first_tie: got %b expected 10", {req0_ready, req1_ready});
    end
  endtask

  task automatic test_wrap;
    do_reset();
    req0_valid = 1; req0_op = OP_ADD; req1_valid = 1; req1_op = OP_SUB;
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (65536) @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    #1;
    n_vec++;
    if (op_count !== 16'hFFFF) begin
      n_err++; $display("FAIL wrap_max: got %0d expected 65535", op_count);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (op_count !== 16'd0) begin
      n_err++; $display("FAIL wrap_zero: got %0d expected 0", op_count);
    end
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 4))
      0: return OP_ADD;
      1: return OP_SUB;
      2: return OP_SLT;
      3: return OP_AND;
      default: return 6'($urandom);
    endcase
  endfunction

  // Reference model: at most one operation executing, plus per-port result slots.
  task automatic test_random;
    logic        ex_v, ex_id, last_port;
    logic [5:0]  ex_op;
    logic [31:0] ex_a, ex_b, ex_res;
    logic        slot_v[2];
    logic [31:0] slot_d[2];
    logic [15:0] done;
    logic        want[2], take[2], elig[2], rdy[2];
    do_reset();
    ex_v = 0; ex_id = 0; ex_op = 0; ex_a = 0; ex_b = 0; ex_res = 0;
    last_port = 1; done = 0;
    for (int p = 0; p < 2; p++) begin slot_v[p] = 0; slot_d[p] = 0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      req0_valid = ($urandom_range(0, 3) != 0); req0_op = pick_op(); req0_a = $urandom; req0_b = $urandom;
      req1_valid = ($urandom_range(0, 3) != 0); req1_op = pick_op(); req1_a = $urandom; req1_b = $urandom;
      rsp0_ready = ($urandom_range(0, 2) != 0);
      rsp1_ready = ($urandom_range(0, 2) != 0);
      #1;
      want[0] = req0_valid; want[1] = req1_valid; rdy[0] = rsp0_ready; rdy[1] = rsp1_ready;
      for (int p = 0; p < 2; p++)
        elig[p] = want[p] && !(ex_v && ex_id == p[0]) && (!slot_v[p] || rdy[p]);
      take[0] = elig[0] && !(elig[1] && last_port == 1'b0);
      take[1] = elig[1] && !take[0];
      n_vec++;
      if ({req0_ready, req1_ready} !== {take[0], take[1]}) begin
        n_err++; $display("FAIL rnd_grant[%0d]: got %b expected %b", cyc, {req0_ready, req1_ready}, {take[0], take[1]});
      end
      n_vec++;
      if (busy !== ex_v || alu_op !== (ex_v ? ex_op : 6'd0) || alu_rv1 !== (ex_v ? ex_a : 32'd0) || alu_rv2 !== (ex_v ? ex_b : 32'd0)) begin
        n_err++; $display("FAIL rnd_alu[%0d]: busy=%b op=%0h rv1=%0h rv2=%0h expected %b %0h %0h %0h",
                          cyc, busy, alu_op, alu_rv1, alu_rv2, ex_v, ex_v ? ex_op : 6'd0, ex_v ? ex_a : 32'd0, ex_v ? ex_b : 32'd0);
      end
      n_vec++;
      if (rsp0_valid !== slot_v[0] || rsp1_valid !== slot_v[1] ||
          (slot_v[0] && rsp0_data !== slot_d[0]) || (slot_v[1] && rsp1_data !== slot_d[1])) begin
        n_err++; $display("FAIL rnd_rsp[%0d]: v0=%b d0=%0h v1=%b d1=%0h expected %b %0h %b %0h",
                          cyc, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, slot_v[0], slot_d[0], slot_v[1], slot_d[1]);
      end
      n_vec++;
      if (op_count !== done) begin
        n_err++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", cyc, op_count, done);
      end
      @(posedge clk);
      for (int p = 0; p < 2; p++)
        if (slot_v[p] && rdy[p]) slot_v[p] = 0;
      if (ex_v) begin
        slot_v[ex_id] = 1; slot_d[ex_id] = ex_res; done = done + 16'd1;
      end
      ex_v = take[0] || take[1];
      if (ex_v) begin
        ex_id = take[1];
        ex_op = take[1] ? req1_op : req0_op;
        ex_a  = take[1] ? req1_a  : req0_a;
        ex_b  = take[1] ? req1_b  : req0_b;
        ex_res = alu_fn(ex_op, ex_a, ex_b);
        last_port = ex_id;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
